serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 147 ++++++++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder: sum = a^b^c, carry = majority(a,b,c).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, one bit per cycle; out_valid rises WIDTH+1 cycles after accept, holds until out_ready.
// SERIAL_ADDER_SUB_EN enables in_sub (A - B); otherwise in_sub is ignored.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int                CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               release_res;
    logic               last_bit;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    assign accept      = in_valid && in_ready_q;
    assign release_res = out_valid_q && out_ready;
    assign last_bit    = (cnt_q == CNT_LAST);

`ifdef SERIAL_ADDER_SUB_EN
    // Two's complement subtract: invert B and inject a carry of one.
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1  : in_cin;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_load     = in_b;
    assign c_load     = in_cin;
`endif

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .c  (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = RUN;
            RUN:     if (last_bit)    state_d = DONE;
            DONE:    if (release_res) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // out_valid trails DONE entry by one cycle, giving the WIDTH+1 latency.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == RUN);
        out_valid_d = (state_q == DONE) && (state_d == DONE);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == IDLE && accept) begin
            a_d     = in_a;
            b_d     = b_load;
            carry_d = c_load;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
            if (last_bit) begin
                cout_d = fa_co;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input bit toggle, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_cin   = 1'($urandom);
                in_sub   = 1'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("result_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_in_ready_after_release", 32'(in_ready), 32'd1);
        check("out_valid_low_after_release", 32'(out_valid), 32'd0);
    endtask

    task automatic run_and_check(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub, input bit toggle,
                                 input logic [7:0] es, input logic eco);
        int lat;
        start_op(a, b, cin, sub);
        wait_result(toggle, lat);
        check({name, "_latency"}, 32'(lat), 32'd9);
        check({name, "_sum"}, 32'(out_sum), 32'(es));
        check({name, "_cout"}, 32'(out_cout), 32'(eco));
        release_out();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [8:0] model;
        logic [7:0] ra, rb;
        logic       rc, rs;
        int         lat;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum", 32'(out_sum), 32'd0);
        check("reset_cout", 32'(out_cout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                          (i % 2) == 1, vecs[i].s, vecs[i].co);
        end

        // Hold the result in DONE while upstream keeps offering.
        start_op(8'h12, 8'h34, 1'b1, 1'b0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd0);
        check("run_out_valid", 32'(out_valid), 32'd0);
        wait_result(1'b0, lat);
        check("hold_latency", 32'(lat), 32'd9);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_sum", 32'(out_sum), 32'h47);
            check("hold_cout", 32'(out_cout), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        run_and_check("b2b0", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0);
        run_and_check("b2b1", 8'hC0, 8'h41, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1);

        // Asynchronous reset in the 4th RUN cycle aborts the operation.
        start_op(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_sum", 32'(out_sum), 32'd0);
        check("midrun_rst_cout", 32'(out_cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_and_check("after_rst", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_and_check("sub0", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0);
        run_and_check("sub1", 8'h20, 8'h10, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1);
`endif

        for (int r = 0; r < 1000; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
            model = rs ? ({1'b0, ra} + {1'b0, ~rb} + 9'd1) : ({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
`else
            rs = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
`endif
            run_and_check("rand", ra, rb, rc, rs, 1'b1, model[7:0], model[8]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
